imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe_if.sv | 24 ++
 rtl/imm_extend_pipe.sv | 130 +++++++++++++
 tb/tb_imm_extend_pipe.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: instruction/format in, extended immediate out.
interface imm_extend_pipe_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       Instr;
  logic [2:0]        Ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] BusImm;
  logic              ImmErr;
  logic [7:0]        ErrCount;

  modport master (
    output in_valid, Instr, Ctrl, out_ready,
    input  in_ready, out_valid, BusImm, ImmErr, ErrCount
  );

  modport slave (
    input  in_valid, Instr, Ctrl, out_ready,
    output in_ready, out_valid, BusImm, ImmErr, ErrCount
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// A64 immediate extraction/extension with a one-cycle output register and a skid buffer,
// so in_ready is registered and never depends combinationally on out_ready.
module imm_extend_pipe #(
  parameter int DATA_W   = 64,
  parameter int BR_SCALE = 1
) (
  input logic              CLK,
  input logic              Reset_n,
  imm_extend_pipe_if.slave bus
);

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("imm_extend_pipe: DATA_W must be 32 or 64");
  end

  // Returns {err, imm64}; imm64 is the full 64-bit result before truncation to DATA_W.
  function automatic logic [64:0] extend_f(input logic [31:0] instr, input logic [2:0] ctrl);
    logic [63:0] v;
    logic        e;
    v = 64'd0;
    e = 1'b0;
    case (ctrl)
      3'b000: v = instr[22] ? {40'd0, instr[21:10], 12'd0} : {52'd0, instr[21:10]};
      3'b001: v = {{55{instr[20]}}, instr[20:12]};
      3'b010: v = {{38{instr[25]}}, instr[25:0]} << ((BR_SCALE != 0) ? 6'd2 : 6'd0);
      3'b011: v = {{45{instr[23]}}, instr[23:5]} << ((BR_SCALE != 0) ? 6'd2 : 6'd0);
      3'b100: begin
        if ((DATA_W == 32) && instr[22]) begin
          v = 64'd0;
          e = 1'b1;
        end else begin
          v = {48'd0, instr[20:5]} << {instr[22:21], 4'd0};
        end
      end
      3'b101: v = {{43{instr[23]}}, instr[23:5], instr[30:29]};
      3'b110: v = {{43{instr[23]}}, instr[23:5], instr[30:29]} << 6'd12;
      default: begin
        v = 64'd0;
        e = 1'b1;
      end
    endcase
    return {e, v};
  endfunction

  logic [64:0]       ext_s;
  logic [DATA_W-1:0] new_imm_s;
  logic              new_err_s;
  logic              accept_s;
  logic              drain_s;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_imm_q,   out_imm_d;
  logic              out_err_q,   out_err_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_imm_q,  skid_imm_d;
  logic              skid_err_q,  skid_err_d;
  logic              in_ready_q,  in_ready_d;
  logic [7:0]        err_cnt_q,   err_cnt_d;

  assign ext_s     = extend_f(bus.Instr, bus.Ctrl);
  assign new_imm_s = ext_s[DATA_W-1:0];
  assign new_err_s = ext_s[64];
  assign accept_s  = bus.in_valid & in_ready_q;
  assign drain_s   = out_valid_q & bus.out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_err_d   = skid_err_q;
    // Output slot free this edge: refill from skid first to keep acceptance order.
    if (!out_valid_q || drain_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        out_valid_d = 1'b1;
        out_imm_d   = new_imm_s;
        out_err_d   = new_err_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = new_imm_s;
      skid_err_d   = new_err_s;
    end else begin
      skid_valid_d = skid_valid_q;
    end
    in_ready_d = ~skid_valid_d;
    if (accept_s && new_err_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.BusImm    = out_imm_q;
  assign bus.ImmErr    = out_err_q;
  assign bus.ErrCount  = err_cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench: one 64-bit and one 32-bit instance fed identical stimulus.
module tb_imm_extend_pipe;

  logic        CLK;
  logic        Reset_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  ctrl;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  imm_extend_pipe_if #(.DATA_W(64)) bus64 ();
  imm_extend_pipe_if #(.DATA_W(32)) bus32 ();

  assign bus64.in_valid  = in_valid;
  assign bus64.Instr     = instr;
  assign bus64.Ctrl      = ctrl;
  assign bus64.out_ready = out_ready;
  assign bus32.in_valid  = in_valid;
  assign bus32.Instr     = instr;
  assign bus32.Ctrl      = ctrl;
  assign bus32.out_ready = out_ready;

  imm_extend_pipe #(.DATA_W(64), .BR_SCALE(1)) dut64 (.CLK(CLK), .Reset_n(Reset_n), .bus(bus64));
  imm_extend_pipe #(.DATA_W(32), .BR_SCALE(1)) dut32 (.CLK(CLK), .Reset_n(Reset_n), .bus(bus32));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  ctrl;
    logic [63:0] e64;
    logic        r64;
    logic [31:0] e32;
    logic        r32;
  } vec_t;

  vec_t vecs [15];
  int   exp_cnt64;
  int   exp_cnt32;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs = '{
      '{32'h007F_FC00, 3'd0, 64'h0000_0000_00FF_F000, 1'b0, 32'h00FF_F000, 1'b0},
      '{32'h0004_8C00, 3'd0, 64'h0000_0000_0000_0123, 1'b0, 32'h0000_0123, 1'b0},
      '{32'h001F_F000, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0},
      '{32'h000A_B000, 3'd1, 64'h0000_0000_0000_00AB, 1'b0, 32'h0000_00AB, 1'b0},
      '{32'h03FF_FFFF, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0},
      '{32'h0000_0010, 3'd2, 64'h0000_0000_0000_0040, 1'b0, 32'h0000_0040, 1'b0},
      '{32'h0080_0000, 3'd3, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 32'hFFF0_0000, 1'b0},
      '{32'h0075_79A0, 3'd4, 64'hABCD_0000_0000_0000, 1'b0, 32'h0000_0000, 1'b1},
      '{32'h0022_4680, 3'd4, 64'h0000_0000_1234_0000, 1'b0, 32'h1234_0000, 1'b0},
      '{32'h0055_79A0, 3'd4, 64'h0000_ABCD_0000_0000, 1'b0, 32'h0000_0000, 1'b1},
      '{32'h6080_0000, 3'd5, 64'hFFFF_FFFF_FFF0_0003, 1'b0, 32'hFFF0_0003, 1'b0},
      '{32'h6080_0000, 3'd6, 64'hFFFF_FFFF_0000_3000, 1'b0, 32'h0000_3000, 1'b0},
      '{32'h2000_0020, 3'd5, 64'h0000_0000_0000_0005, 1'b0, 32'h0000_0005, 1'b0},
      '{32'hFFFF_FFFF, 3'd7, 64'h0000_0000_0000_0000, 1'b1, 32'h0000_0000, 1'b1},
      '{32'h2000_0020, 3'd6, 64'h0000_0000_0000_5000, 1'b0, 32'h0000_5000, 1'b0}
    };

    // Reset with a valid input presented; it must be discarded.
    Reset_n = 1'b0; in_valid = 1'b1; instr = 32'h007F_FC00; ctrl = 3'd0; out_ready = 1'b1;
    repeat (3) step();
    check_eq("rst_out_valid64", {63'd0, bus64.out_valid}, 64'd0);
    check_eq("rst_busimm64", bus64.BusImm, 64'd0);
    check_eq("rst_immerr64", {63'd0, bus64.ImmErr}, 64'd0);
    check_eq("rst_errcnt64", {56'd0, bus64.ErrCount}, 64'd0);
    check_eq("rst_in_ready64", {63'd0, bus64.in_ready}, 64'd0);
    check_eq("rst_out_valid32", {63'd0, bus32.out_valid}, 64'd0);
    Reset_n = 1'b1; in_valid = 1'b0;
    step();
    check_eq("post_rst_in_ready", {63'd0, bus64.in_ready}, 64'd1);
    check_eq("post_rst_out_valid", {63'd0, bus64.out_valid}, 64'd0);

    // Format table, back-to-back with out_ready=1.
    exp_cnt64 = 0;
    exp_cnt32 = 0;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; instr = vecs[i].instr; ctrl = vecs[i].ctrl;
      step();
      if (vecs[i].r64) exp_cnt64++;
      if (vecs[i].r32) exp_cnt32++;
      check_eq($sformatf("v%0d_valid64", i), {63'd0, bus64.out_valid}, 64'd1);
      check_eq($sformatf("v%0d_imm64", i), bus64.BusImm, vecs[i].e64);
      check_eq($sformatf("v%0d_err64", i), {63'd0, bus64.ImmErr}, {63'd0, vecs[i].r64});
      check_eq($sformatf("v%0d_cnt64", i), {56'd0, bus64.ErrCount}, 64'(exp_cnt64));
      check_eq($sformatf("v%0d_imm32", i), {32'd0, bus32.BusImm}, {32'd0, vecs[i].e32});
      check_eq($sformatf("v%0d_err32", i), {63'd0, bus32.ImmErr}, {63'd0, vecs[i].r32});
      check_eq($sformatf("v%0d_cnt32", i), {56'd0, bus32.ErrCount}, 64'(exp_cnt32));
    end
    in_valid = 1'b0;
    step();
    check_eq("table_drained", {63'd0, bus64.out_valid}, 64'd0);

    // Back-pressure: A held, B in skid, C stalls, then A,B,C in order.
    out_ready = 1'b0; in_valid = 1'b1; ctrl = 3'd1; instr = 32'h0000_1000;
    step();
    check_eq("bp_A_valid", {63'd0, bus64.out_valid}, 64'd1);
    check_eq("bp_A_imm", bus64.BusImm, 64'd1);
    instr = 32'h0000_2000;
    step();
    check_eq("bp_A_held", bus64.BusImm, 64'd1);
    check_eq("bp_in_ready_drop", {63'd0, bus64.in_ready}, 64'd0);
    instr = 32'h0000_3000;
    step();
    check_eq("bp_A_still", bus64.BusImm, 64'd1);
    check_eq("bp_C_stall", {63'd0, bus64.in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    check_eq("bp_B_out", bus64.BusImm, 64'd2);
    check_eq("bp_B_valid", {63'd0, bus64.out_valid}, 64'd1);
    check_eq("bp_in_ready_back", {63'd0, bus64.in_ready}, 64'd1);
    step();
    check_eq("bp_C_out", bus64.BusImm, 64'd3);
    check_eq("bp_C_valid", {63'd0, bus64.out_valid}, 64'd1);
    in_valid = 1'b0;
    step();
    check_eq("bp_drained", {63'd0, bus64.out_valid}, 64'd0);

    // Streaming: one result per cycle, handshakes continuous.
    in_valid = 1'b1; ctrl = 3'd1;
    for (int i = 0; i < 16; i++) begin
      instr = 32'(i) << 12;
      step();
      check_eq($sformatf("st%0d_valid", i), {63'd0, bus64.out_valid}, 64'd1);
      check_eq($sformatf("st%0d_imm", i), bus64.BusImm, 64'(i));
      check_eq($sformatf("st%0d_in_ready", i), {63'd0, bus64.in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    check_eq("st_drained", {63'd0, bus64.out_valid}, 64'd0);

    // Error counter saturation.
    in_valid = 1'b1; ctrl = 3'd7; instr = 32'h0;
    repeat (300) step();
    in_valid = 1'b0;
    step();
    check_eq("sat_cnt64", {56'd0, bus64.ErrCount}, 64'd255);
    check_eq("sat_cnt32", {56'd0, bus32.ErrCount}, 64'd255);

    // Reset with output and skid both full.
    out_ready = 1'b0; in_valid = 1'b1; ctrl = 3'd1; instr = 32'h0000_5000;
    step();
    instr = 32'h0000_6000;
    step();
    check_eq("mid_pre_valid", {63'd0, bus64.out_valid}, 64'd1);
    check_eq("mid_pre_in_ready", {63'd0, bus64.in_ready}, 64'd0);
    Reset_n = 1'b0;
    step();
    check_eq("mid_rst_valid", {63'd0, bus64.out_valid}, 64'd0);
    check_eq("mid_rst_cnt", {56'd0, bus64.ErrCount}, 64'd0);
    check_eq("mid_rst_in_ready", {63'd0, bus64.in_ready}, 64'd0);
    check_eq("mid_rst_imm", bus64.BusImm, 64'd0);
    Reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_eq("mid_post_in_ready", {63'd0, bus64.in_ready}, 64'd1);
    check_eq("mid_post_valid", {63'd0, bus64.out_valid}, 64'd0);
    step();
    check_eq("mid_no_skid_leak", {63'd0, bus64.out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
